// File: rtl/countdown_timer.sv
// Game countdown clock: credits and BCD seconds in, expiry and low-time warning out.
// Optional blinking low_time warning is built when COUNTDOWN_BLINK_EN is defined.
module countdown_timer #(
    parameter int FRAMES_PER_SEC = 30,
    parameter int LOW_TIME       = 10,
    parameter int MAX_TIME       = 999
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            startOfFrame,
    input  logic            add_time,
    input  logic [1:0][3:0] time_to_add,
    input  logic            pause,
    input  logic            enable,
    output logic [2:0][3:0] time_digits,
    output logic            out_of_time,
    output logic            low_time
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [5:0]      frame_cnt_r, frame_cnt_nxt_s;
    logic [2:0][3:0] time_r, time_nxt_s;
    logic [10:0]     cur_bin_s, credit_bin_s, sum_s, sat_s, time_bin_nxt_s;
    logic            credit_ok_s, go_s, count_s, wrap_s;
    logic            oot_r, low_r, low_cond_nxt_s, low_nxt_s;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [10:0] bcd_to_bin(input logic [2:0][3:0] b);
        return 11'(b[2]) * 11'd100 + 11'(b[1]) * 11'd10 + 11'(b[0]);
    endfunction

    // Inputs are always <= MAX_TIME (<= 999), so each quotient fits one digit.
    function automatic logic [2:0][3:0] bin_to_bcd(input logic [10:0] v);
        logic [2:0][3:0] r;
        r[2] = 4'(v / 11'd100);
        r[1] = 4'((v / 11'd10) % 11'd10);
        r[0] = 4'(v % 11'd10);
        return r;
    endfunction

    // Credit/decrement arithmetic shared by every state; the FSM picks when it applies.
    always_comb begin
        cur_bin_s    = bcd_to_bin(time_r);
        credit_bin_s = 11'(clamp_digit(time_to_add[1])) * 11'd10
                     + 11'(clamp_digit(time_to_add[0]));
        credit_ok_s  = add_time && (credit_bin_s != 11'd0);
        go_s         = !pause && enable;
        count_s      = (state_r == RUN) && startOfFrame && go_s;
        wrap_s       = count_s && (frame_cnt_r == 6'(FRAMES_PER_SEC - 1));
        sum_s        = cur_bin_s + (credit_ok_s ? credit_bin_s : 11'd0)
                     - (wrap_s ? 11'd1 : 11'd0);
        sat_s        = (sum_s > 11'(MAX_TIME)) ? 11'(MAX_TIME) : sum_s;
    end

    // Next-state, next-time and frame counter decode.
    always_comb begin
        state_nxt_s     = state_r;
        frame_cnt_nxt_s = frame_cnt_r;
        time_bin_nxt_s  = cur_bin_s;
        case (state_r)
            IDLE: begin
                if (credit_ok_s) begin
                    time_bin_nxt_s  = sat_s;
                    frame_cnt_nxt_s = 6'd0;
                    state_nxt_s     = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (credit_ok_s || wrap_s) begin
                    time_bin_nxt_s = sat_s;
                end else begin
                    time_bin_nxt_s = cur_bin_s;
                end
                if (wrap_s) begin
                    frame_cnt_nxt_s = 6'd0;
                end else if (count_s) begin
                    frame_cnt_nxt_s = frame_cnt_r + 6'd1;
                end else begin
                    frame_cnt_nxt_s = frame_cnt_r;
                end
                // A same-cycle nonzero credit keeps sat_s above zero, so no expiry then.
                if (!go_s) begin
                    state_nxt_s = PAUSED;
                end else if (wrap_s && (sat_s == 11'd0)) begin
                    state_nxt_s = EXPIRED;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            PAUSED: begin
                if (credit_ok_s) begin
                    time_bin_nxt_s = sat_s;
                end else begin
                    time_bin_nxt_s = cur_bin_s;
                end
                if (go_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = PAUSED;
                end
            end
            EXPIRED: begin
                state_nxt_s = EXPIRED;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        time_nxt_s     = bin_to_bcd(time_bin_nxt_s);
        low_cond_nxt_s = ((state_nxt_s == RUN) || (state_nxt_s == PAUSED))
                      && (time_bin_nxt_s >= 11'd1)
                      && (time_bin_nxt_s <= 11'(LOW_TIME));
    end

`ifdef COUNTDOWN_BLINK_EN
    logic [2:0] blink_cnt_r, blink_cnt_nxt_s;
    logic       low_cond_r;

    // Blink: start high on entry to the low window, toggle every 8th frame pulse.
    always_comb begin
        low_nxt_s       = low_r;
        blink_cnt_nxt_s = blink_cnt_r;
        if (!low_cond_nxt_s) begin
            low_nxt_s       = 1'b0;
            blink_cnt_nxt_s = 3'd0;
        end else if (!low_cond_r) begin
            low_nxt_s       = 1'b1;
            blink_cnt_nxt_s = 3'd0;
        end else if (startOfFrame) begin
            blink_cnt_nxt_s = blink_cnt_r + 3'd1;
            low_nxt_s       = (blink_cnt_r == 3'd7) ? !low_r : low_r;
        end else begin
            low_nxt_s       = low_r;
            blink_cnt_nxt_s = blink_cnt_r;
        end
    end

    // Blink counter and previous low-window condition.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink_cnt_r <= 3'd0;
            low_cond_r  <= 1'b0;
        end else begin
            blink_cnt_r <= blink_cnt_nxt_s;
            low_cond_r  <= low_cond_nxt_s;
        end
    end
`else
    // Steady warning level.
    always_comb begin
        low_nxt_s = low_cond_nxt_s;
    end
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r     <= IDLE;
            frame_cnt_r <= 6'd0;
            time_r      <= 12'h000;
            oot_r       <= 1'b0;
            low_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            frame_cnt_r <= frame_cnt_nxt_s;
            time_r      <= time_nxt_s;
            oot_r       <= (state_nxt_s == EXPIRED);
            low_r       <= low_nxt_s;
        end
    end

    assign time_digits = time_r;
    assign out_of_time = oot_r;
    assign low_time    = low_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed, table-driven bench for countdown_timer (FRAMES_PER_SEC=4 and 30 instances).
module tb_countdown_timer;

    logic            clk = 1'b0;
    logic            resetN, startOfFrame, add_time, pause, enable;
    logic [1:0][3:0] time_to_add;
    logic [2:0][3:0] digits4, digits30;
    logic            oot4, oot30, low4, low30;
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    countdown_timer #(.FRAMES_PER_SEC(4), .LOW_TIME(10), .MAX_TIME(999)) dut4 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .add_time(add_time),
        .time_to_add(time_to_add), .pause(pause), .enable(enable),
        .time_digits(digits4), .out_of_time(oot4), .low_time(low4)
    );

    countdown_timer #(.FRAMES_PER_SEC(30), .LOW_TIME(10), .MAX_TIME(999)) dut30 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .add_time(add_time),
        .time_to_add(time_to_add), .pause(pause), .enable(enable),
        .time_digits(digits30), .out_of_time(oot30), .low_time(low30)
    );

    typedef struct {
        string       name;
        logic        add;
        logic [3:0]  tens;
        logic [3:0]  units;
        logic        sof;
        logic        pse;
        logic        en;
        logic [11:0] exp_digits;
        logic        exp_oot;
        logic        exp_low;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [11:0] got_d, input logic got_o,
                         input logic got_l, input logic [11:0] exp_d, input logic exp_o,
                         input logic exp_l);
        checks++;
        if ({got_d, got_o, got_l} !== {exp_d, exp_o, exp_l}) begin
            errors++;
            $display("FAIL %s: got digits=%03h oot=%0b low=%0b, expected digits=%03h oot=%0b low=%0b",
                     name, got_d, got_o, got_l, exp_d, exp_o, exp_l);
        end
    endtask

    task automatic chk4(input string name, input logic [11:0] exp_d, input logic exp_o,
                        input logic exp_l);
        check(name, digits4, oot4, low4, exp_d, exp_o, exp_l);
    endtask

    task automatic cyc(input logic a, input logic [3:0] t, input logic [3:0] u,
                       input logic s, input logic p, input logic e);
        add_time     = a;
        time_to_add  = {t, u};
        startOfFrame = s;
        pause        = p;
        enable       = e;
        @(posedge clk);
        #1;
        add_time     = 1'b0;
        startOfFrame = 1'b0;
    endtask

    task automatic frames(input int n, input logic p, input logic e);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 4'd0, 1'b1, p, e);
    endtask

    task automatic do_reset();
        resetN       = 1'b0;
        add_time     = 1'b0;
        startOfFrame = 1'b0;
        time_to_add  = 8'h00;
        pause        = 1'b0;
        enable       = 1'b1;
        #12;
        chk4("reset_dut4", 12'h000, 1'b0, 1'b0);
        resetN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_blink_low;
        resetN = 1'b1; add_time = 1'b0; startOfFrame = 1'b0;
        time_to_add = 8'h00; pause = 1'b0; enable = 1'b1;
        tbl[0]  = '{"idle_add00",  1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0};
        tbl[1]  = '{"idle_sof",    1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0};
        tbl[2]  = '{"load02",      1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1, 12'h002, 1'b0, 1'b1};
        tbl[3]  = '{"f1",          1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 12'h002, 1'b0, 1'b1};
        tbl[4]  = '{"f2",          1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 12'h002, 1'b0, 1'b1};
        tbl[5]  = '{"f3",          1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 12'h002, 1'b0, 1'b1};
        tbl[6]  = '{"f4",          1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 12'h001, 1'b0, 1'b1};
        tbl[7]  = '{"f5",          1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 12'h001, 1'b0, 1'b1};
        tbl[8]  = '{"f6",          1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 12'h001, 1'b0, 1'b1};
        tbl[9]  = '{"f7",          1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 12'h001, 1'b0, 1'b1};
        tbl[10] = '{"f8_expire",   1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0};
        tbl[11] = '{"exp_add10",   1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0};
        tbl[12] = '{"exp_sof",     1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0};
        tbl[13] = '{"exp_add_sof", 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0};
        #1;

        // Credit 99 then 30 frames on both rates.
        do_reset();
        check("reset_dut30", digits30, oot30, low30, 12'h000, 1'b0, 1'b0);
        cyc(1'b1, 4'd9, 4'd9, 1'b0, 1'b0, 1'b1);
        chk4("load99", 12'h099, 1'b0, 1'b0);
        check("load99_dut30", digits30, oot30, low30, 12'h099, 1'b0, 1'b0);
        frames(30, 1'b0, 1'b1);
        check("30frames_dut30", digits30, oot30, low30, 12'h098, 1'b0, 1'b0);
        chk4("30frames_dut4", 12'h092, 1'b0, 1'b0);

        // IDLE behaviour, expiry and sticky flag.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].add, tbl[i].tens, tbl[i].units, tbl[i].sof, tbl[i].pse, tbl[i].en);
            chk4(tbl[i].name, tbl[i].exp_digits, tbl[i].exp_oot, tbl[i].exp_low);
        end

        // Saturation and digit clamping.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 4'd9, 4'd9, 1'b0, 1'b0, 1'b1);
        chk4("load990", 12'h990, 1'b0, 1'b0);
        cyc(1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1);
        chk4("load995", 12'h995, 1'b0, 1'b0);
        cyc(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b1);
        chk4("sat999", 12'h999, 1'b0, 1'b0);
        cyc(1'b1, 4'd9, 4'd15, 1'b0, 1'b0, 1'b1);
        chk4("clamp9F", 12'h999, 1'b0, 1'b0);
        frames(4, 1'b0, 1'b1);
        chk4("sat_count", 12'h998, 1'b0, 1'b0);

        // Credit and final decrement in the same cycle.
        do_reset();
        cyc(1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1);
        frames(19, 1'b0, 1'b1);
        chk4("at001_cnt3", 12'h001, 1'b0, 1'b1);
        cyc(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1);
        exp_blink_low = 1'b1;
        chk4("credit_dec", 12'h010, 1'b0, exp_blink_low);
`ifdef COUNTDOWN_BLINK_EN
        exp_blink_low = 1'b0;
`endif
        frames(4, 1'b0, 1'b1);
        chk4("after_credit_dec", 12'h009, 1'b0, exp_blink_low);

        // Pause and enable hold the count and preserve the frame counter.
        do_reset();
        cyc(1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 1'b1);
        frames(2, 1'b0, 1'b1);
        cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1);
        frames(100, 1'b1, 1'b1);
        chk4("paused100", 12'h050, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        frames(1, 1'b0, 1'b1);
        chk4("resume_f3", 12'h050, 1'b0, 1'b0);
        frames(1, 1'b0, 1'b1);
        chk4("resume_wrap", 12'h049, 1'b0, 1'b0);
        frames(10, 1'b0, 1'b0);
        chk4("disabled10", 12'h049, 1'b0, 1'b0);
        cyc(1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0);
        chk4("paused_credit", 12'h051, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        frames(3, 1'b0, 1'b1);
        chk4("enable_f3", 12'h051, 1'b0, 1'b0);
        frames(1, 1'b0, 1'b1);
        chk4("enable_wrap", 12'h050, 1'b0, 1'b0);

        // Low-time window entry, then asynchronous reset mid-count.
        do_reset();
        cyc(1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b1);
        chk4("load11", 12'h011, 1'b0, 1'b0);
        frames(3, 1'b0, 1'b1);
        chk4("low_pre", 12'h011, 1'b0, 1'b0);
        frames(1, 1'b0, 1'b1);
        chk4("low_rise", 12'h010, 1'b0, 1'b1);
        frames(7, 1'b0, 1'b1);
        chk4("low_7f", 12'h009, 1'b0, 1'b1);
        exp_blink_low = 1'b1;
`ifdef COUNTDOWN_BLINK_EN
        exp_blink_low = 1'b0;
`endif
        frames(1, 1'b0, 1'b1);
        chk4("low_8f", 12'h008, 1'b0, exp_blink_low);
        frames(2, 1'b0, 1'b1);
        resetN = 1'b0;
        #2;
        chk4("async_reset", 12'h000, 1'b0, 1'b0);
        #5;
        resetN = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
